// File: rtl/gf_exp_ctrl.sv
// rtl/gf_exp_ctrl.sv - GF(2^M) exponentiation sequencer (left-to-right square-and-multiply)
//
// Computes c = a^e by driving an external registered GF(2^M) multiplier.
// Each step presents operands on mul_a_out/mul_b_out and captures mul_c_in
// MUL_LAT cycles later. Main use is field inversion (e = 2^M-2).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request, sampled only when idle
//   a_in       base operand, captured on start
//   e_in       exponent, captured on start
//   busy       high while an operation is in progress
//   done       one-cycle pulse, c_out valid from this cycle
//   c_out      result, held until the next done
//   zero_err   (GF_EXP_ZERO_ERR_EN only) inversion of zero requested
//   mul_a_out  multiplier operand A (registered)
//   mul_b_out  multiplier operand B (registered)
//   mul_c_in   multiplier product
//
// Build option: define GF_EXP_ZERO_ERR_EN to add the zero_err port and the
// fast-fail path for inverting zero.

module gf_exp_ctrl #(
    parameter int M       = 16,
    parameter int MUL_LAT = 1,
    parameter int CW      = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] a_in,
    input  logic [M-1:0] e_in,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] c_out,
`ifdef GF_EXP_ZERO_ERR_EN
    output logic         zero_err,
`endif
    output logic [M-1:0] mul_a_out,
    output logic [M-1:0] mul_b_out,
    input  logic [M-1:0] mul_c_in
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SQ_ISS  = 3'd1,
        S_SQ_WAIT = 3'd2,
        S_ML_ISS  = 3'd3,
        S_ML_WAIT = 3'd4
    } state_t;

    state_t        state, state_nxt;

    logic [M-1:0]  a_reg;
    logic [M-1:0]  e_reg;
    logic [M-1:0]  r;
    logic [M-1:0]  r_nxt;
    logic [CW-1:0] idx;
    logic [CW-1:0] wait_cnt;

    logic          accept;
    logic          zero_hit;
    logic          in_iss;
    logic          in_wait;
    logic          cap;
    logic          e_bit;
    logic          go_mul;
    logic          last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && !zero_hit) begin
                    state_nxt = S_SQ_ISS;
                end
            end
            S_SQ_ISS:  state_nxt = S_SQ_WAIT;
            S_ML_ISS:  state_nxt = S_ML_WAIT;
            S_SQ_WAIT,
            S_ML_WAIT: begin
                // The NEXT decision is folded into the capturing edge.
                if (cap) begin
                    if (go_mul) begin
                        state_nxt = S_ML_ISS;
                    end else if (last) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_SQ_ISS;
                    end
                end
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Output / strobe logic
    always_comb begin
        busy    = (state != S_IDLE);
        // done is still high in the first idle cycle; a start seen then is dropped.
        accept  = (state == S_IDLE) && start && !done;
        in_iss  = (state == S_SQ_ISS) || (state == S_ML_ISS);
        in_wait = (state == S_SQ_WAIT) || (state == S_ML_WAIT);
        cap     = in_wait && (wait_cnt == CW'(1));
        e_bit   = |(e_reg & ({{(M-1){1'b0}}, 1'b1} << idx));
        go_mul  = cap && (state == S_SQ_WAIT) && e_bit;
        last    = cap && !go_mul && (idx == '0);
`ifdef GF_EXP_ZERO_ERR_EN
        zero_hit = accept && (a_in == '0) && (e_in == {{(M-1){1'b1}}, 1'b0});
`else
        zero_hit = 1'b0;
`endif
        r_nxt = r;
        if (accept) begin
            r_nxt = {{(M-1){1'b0}}, 1'b1};
        end else if (cap) begin
            r_nxt = mul_c_in;
        end
    end

    // Datapath. Operand registers are loaded on the edge that enters an
    // ISS state, so the multiplier sees them for the whole ISS+WAIT window.
    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b0;
            c_out     <= '0;
            mul_a_out <= '0;
            mul_b_out <= '0;
            a_reg     <= '0;
            e_reg     <= '0;
            r         <= '0;
            idx       <= '0;
            wait_cnt  <= '0;
`ifdef GF_EXP_ZERO_ERR_EN
            zero_err  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            r    <= r_nxt;

            if (accept) begin
`ifdef GF_EXP_ZERO_ERR_EN
                zero_err <= zero_hit;
`endif
                if (zero_hit) begin
                    done  <= 1'b1;
                    c_out <= '0;
                end else begin
                    a_reg     <= a_in;
                    e_reg     <= e_in;
                    idx       <= CW'(M - 1);
                    mul_a_out <= r_nxt;
                    mul_b_out <= r_nxt;
                end
            end

            if (in_iss) begin
                wait_cnt <= CW'(MUL_LAT);
            end else if (in_wait) begin
                wait_cnt <= wait_cnt - CW'(1);
            end

            if (cap) begin
                if (go_mul) begin
                    mul_a_out <= r_nxt;
                    mul_b_out <= a_reg;
                end else if (last) begin
                    c_out <= r_nxt;
                    done  <= 1'b1;
                end else begin
                    idx       <= idx - CW'(1);
                    mul_a_out <= r_nxt;
                    mul_b_out <= r_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_gf_exp_ctrl.sv
// tb/tb_gf_exp_ctrl.sv - self-checking bench for gf_exp_ctrl

module tb_gf_exp_ctrl;

    localparam int M = 16;
    localparam int L = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] e_in = '0;
    logic        busy;
    logic        done;
    logic [15:0] c_out;
    logic [15:0] mul_a_out;
    logic [15:0] mul_b_out;
    logic [15:0] mul_c_in = '0;
`ifdef GF_EXP_ZERO_ERR_EN
    logic        zero_err;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gf_exp_ctrl #(.M(M), .MUL_LAT(L), .CW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .e_in      (e_in),
        .busy      (busy),
        .done      (done),
        .c_out     (c_out),
`ifdef GF_EXP_ZERO_ERR_EN
        .zero_err  (zero_err),
`endif
        .mul_a_out (mul_a_out),
        .mul_b_out (mul_b_out),
        .mul_c_in  (mul_c_in)
    );

    function automatic logic [15:0] gf_mul(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < 16; i++)
            if (y[i]) p = p ^ (32'(x) << i);
        for (int i = 31; i >= 16; i--)
            if (p[i]) p = p ^ (32'h1002D << (i - 16));
        return p[15:0];
    endfunction

    function automatic logic [15:0] gf_pow(input logic [15:0] a, input logic [15:0] e);
        logic [15:0] res, base;
        res  = 16'h0001;
        base = a;
        for (int i = 0; i < 16; i++) begin
            if (e[i]) res = gf_mul(res, base);
            base = gf_mul(base, base);
        end
        return res;
    endfunction

    // Stand-in for the registered single-cycle field multiplier.
    always @(posedge clk) mul_c_in <= gf_mul(mul_a_out, mul_b_out);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; issues start and follows the operation.
    task automatic run_op(input logic [15:0] a, input logic [15:0] e,
                          input bit poke, input int rst_at);
        logic [15:0] exp_c;
        logic [15:0] c0;
        int          exp_lat;
        int          n;
        int          busy_bad;
        int          stable_bad;
        int          ndone;
        bit          seen;
        bit          zcase;
        exp_c   = gf_pow(a, e);
        exp_lat = (M + $countones(e)) * (L + 1) + 1;
        zcase   = 1'b0;
`ifdef GF_EXP_ZERO_ERR_EN
        if (a == 16'h0 && e == 16'hFFFE) begin
            zcase   = 1'b1;
            exp_lat = 1;
        end
`endif
        c0         = c_out;
        busy_bad   = 0;
        stable_bad = 0;
        seen       = 1'b0;
        n          = 0;
        start = 1'b1;
        a_in  = a;
        e_in  = e;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) busy_bad++;
                if (c_out !== c0) stable_bad++;
            end
            start = poke && (n == 5 || n == 40);
            a_in  = 16'($urandom);
            e_in  = 16'($urandom);
            if (rst_at > 0 && n == rst_at) begin
                rst   = 1'b1;
                start = 1'b0;
                @(negedge clk);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_c_out", 32'(c_out), 32'd0);
                check("rst_mul_a", 32'(mul_a_out), 32'd0);
                check("rst_mul_b", 32'(mul_b_out), 32'd0);
                rst   = 1'b0;
                ndone = 0;
                for (int k = 0; k < 80; k++) begin
                    @(negedge clk);
                    if (done) ndone++;
                end
                check("abort_no_done", 32'(ndone), 32'd0);
                return;
            end
        end
        check("latency", seen ? 32'(n) : 32'hFFFFFFFF, 32'(exp_lat));
        check("c_out", 32'(c_out), 32'(exp_c));
        check("busy_at_done", 32'(busy), 32'd0);
        check("busy_during_op", 32'(busy_bad), 32'd0);
        check("c_out_stable", 32'(stable_bad), 32'd0);
`ifdef GF_EXP_ZERO_ERR_EN
        check("zero_err", 32'(zero_err), 32'(zcase));
`endif
        // A start coincident with done must be ignored.
        start = poke;
        a_in  = 16'h0005;
        e_in  = 16'h0003;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("start_at_done_ignored", 32'(busy), 32'd0);
        check("c_out_hold", 32'(c_out), 32'(exp_c));
    endtask

    initial begin
        logic [15:0] ra, re;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_c_out", 32'(c_out), 32'd0);
        check("reset_mul_a", 32'(mul_a_out), 32'd0);
        check("reset_mul_b", 32'(mul_b_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(16'h0002, 16'hFFFE, 1'b0, 0);
        check("inv_x_const", 32'(c_out), 32'h8016);
        run_op(16'h0001, 16'hFFFE, 1'b0, 0);
        check("inv_one_const", 32'(c_out), 32'h0001);
        run_op(16'h0003, 16'h0002, 1'b0, 0);
        check("sq3_const", 32'(c_out), 32'h0005);
        run_op(16'h1234, 16'h0000, 1'b0, 0);
        check("e0_const", 32'(c_out), 32'h0001);
        run_op(16'h00A5, 16'hFFFE, 1'b1, 0);
        run_op(16'h0007, 16'hFFFE, 1'b0, 20);
        @(negedge clk);
        run_op(16'h0002, 16'hFFFE, 1'b0, 0);
        check("inv_after_rst", 32'(c_out), 32'h8016);
        run_op(16'h0000, 16'hFFFE, 1'b0, 0);
        check("inv_zero_const", 32'(c_out), 32'h0000);
        run_op(16'h0000, 16'h0000, 1'b0, 0);
        check("zero_pow_zero", 32'(c_out), 32'h0001);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            re = 16'($urandom);
            if (i % 5 == 0) ra = '0;
            run_op(ra, re, 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
